// File: rtl/dispatch_pkg.sv
// Shared definitions for the task dispatcher and the processor top:
// default task-id / PC widths and the matching typedefs.
package dispatch_pkg;

  localparam int QID_W_DEF = 4;
  localparam int PC_W_DEF  = 16;

  typedef logic [QID_W_DEF-1:0] task_id_t;
  typedef logic [PC_W_DEF-1:0]  pc_t;

  // Advance a round-robin index by one, wrapping at n.
  function automatic int unsigned rr_advance(input int unsigned cur, input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/task_fifo.sv
// Task FIFO with NUM_PUSH priority-ordered push ports (port 0 highest)
// and a single pop. A pop in the same cycle frees a slot for that
// cycle's pushes. Pushes that do not fit are dropped and latch overflow.
module task_fifo
  import dispatch_pkg::*;
#(
  parameter int NUM_PUSH = 5,
  parameter int DEPTH    = 16,
  parameter int QID_W    = QID_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PUSH-1:0]         push_vld,
  input  logic [NUM_PUSH*QID_W-1:0]   push_num,
  input  logic                        pop,
  output logic [$clog2(DEPTH):0]      count,
  output logic [QID_W-1:0]            head,
  output logic [NUM_PUSH-1:0]         accepted,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [QID_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic              overflow_r;

  logic [CW:0]       free_s;
  logic [CW:0]       used_s;
  logic [NUM_PUSH-1:0] accepted_s;
  logic [AW-1:0]     wr_idx_s [NUM_PUSH];
  logic              drop_s;

  // Grant push ports in priority order while free slots remain; each
  // accepted port gets the next consecutive write slot.
  always_comb begin
    free_s     = (CW+1)'(DEPTH) - {1'b0, count_r} + {{CW{1'b0}}, pop};
    used_s     = {(CW+1){1'b0}};
    accepted_s = {NUM_PUSH{1'b0}};
    for (int p = 0; p < NUM_PUSH; p++) begin
      wr_idx_s[p] = wr_ptr_r + used_s[AW-1:0];
      if (push_vld[p] && (used_s < free_s)) begin
        accepted_s[p] = 1'b1;
        used_s        = used_s + {{CW{1'b0}}, 1'b1};
      end else begin
        accepted_s[p] = 1'b0;
      end
    end
    drop_s = |(push_vld & ~accepted_s);
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, pop};
      wr_ptr_r <= wr_ptr_r + used_s[AW-1:0];
      count_r  <= count_r - {{(CW-1){1'b0}}, pop} + used_s[CW-1:0];
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Storage writes; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PUSH; p++) begin
      if (accepted_s[p]) begin
        mem_r[wr_idx_s[p]] <= push_num[p*QID_W +: QID_W];
      end
    end
  end

  assign count    = count_r;
  assign head     = mem_r[rd_ptr_r];
  assign accepted = accepted_s;
  assign overflow = overflow_r;

endmodule

// File: rtl/task_dispatcher.sv
// Task dispatcher: queues task numbers pushed by the host and the cores,
// and hands the entry PC of the oldest task to one requesting core per
// cycle, chosen round-robin.
module task_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DEPTH     = 16,
  parameter int QID_W     = QID_W_DEF,
  parameter int PC_W      = PC_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CORES-1:0]         core_q_wen,
  input  logic [NUM_CORES*QID_W-1:0]   core_q_num,
  input  logic                         host_q_wen,
  input  logic [QID_W-1:0]             host_q_num,
  input  logic [NUM_CORES-1:0]         core_req_pc,
  output logic [NUM_CORES-1:0]         core_set_pc,
  output logic [PC_W-1:0]              new_pc,
  input  logic                         tbl_wen,
  input  logic [QID_W-1:0]             tbl_waddr,
  input  logic [PC_W-1:0]              tbl_wdata,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         idle
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int NP = NUM_CORES + 1;

  logic [PC_W-1:0]      tbl_r [2**QID_W];
  logic [NUM_CORES-1:0] set_pc_r;
  logic [PC_W-1:0]      new_pc_r;
  logic [RW-1:0]        rr_r;

  logic [NUM_CORES-1:0] elig_s;
  logic [NUM_CORES-1:0] grant_s;
  logic [RW-1:0]        win_s;
  logic [RW-1:0]        rr_next_s;
  logic                 found_s;
  logic                 pop_s;
  logic [QID_W-1:0]     head_s;
  logic [CW-1:0]        count_s;
  logic                 overflow_s;
  logic [NP-1:0]        push_accepted_unused_s;

  // Host sits on the highest-priority push port, cores follow in index order.
  task_fifo #(
    .NUM_PUSH (NP),
    .DEPTH    (DEPTH),
    .QID_W    (QID_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld ({core_q_wen, host_q_wen}),
    .push_num ({core_q_num, host_q_num}),
    .pop      (pop_s),
    .count    (count_s),
    .head     (head_s),
    .accepted (push_accepted_unused_s),
    .overflow (overflow_s)
  );

  // Round-robin pick among requesting cores not already in a grant pulse.
  always_comb begin
    elig_s  = core_req_pc & ~set_pc_r;
    found_s = 1'b0;
    win_s   = {RW{1'b0}};
    for (int k = 0; k < NUM_CORES; k++) begin
      int idx;
      idx = (int'(rr_r) + k) % NUM_CORES;
      if (!found_s && elig_s[idx]) begin
        found_s = 1'b1;
        win_s   = RW'(idx);
      end else begin
        found_s = found_s;
      end
    end
    pop_s     = found_s && (count_s != {CW{1'b0}});
    grant_s   = pop_s ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << win_s) : {NUM_CORES{1'b0}};
    rr_next_s = RW'(rr_advance(32'(win_s), 32'(NUM_CORES)));
  end

  // Registered grant pulse, PC and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_pc_r <= {NUM_CORES{1'b0}};
      new_pc_r <= {PC_W{1'b0}};
      rr_r     <= {RW{1'b0}};
    end else if (pop_s) begin
      set_pc_r <= grant_s;
      new_pc_r <= tbl_r[head_s];
      rr_r     <= rr_next_s;
    end else begin
      set_pc_r <= {NUM_CORES{1'b0}};
    end
  end

  // Entry table; a same-cycle dispatch reads the value before this write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**QID_W; i++) begin
        tbl_r[i] <= {PC_W{1'b0}};
      end
    end else if (tbl_wen) begin
      tbl_r[tbl_waddr] <= tbl_wdata;
    end
  end

  assign core_set_pc = set_pc_r;
  assign new_pc      = new_pc_r;
  assign count       = count_s;
  assign overflow    = overflow_s;
  assign idle        = (count_s == {CW{1'b0}}) && (&core_req_pc);

endmodule

// File: tb/tb_task_dispatcher.sv
// Randomized self-checking bench for task_dispatcher against a queue-based
// reference model of the dispatch rules.
module tb_task_dispatcher;

  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int QW    = 4;
  localparam int PW    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   core_q_wen;
  logic [NC*QW-1:0] core_q_num;
  logic            host_q_wen;
  logic [QW-1:0]   host_q_num;
  logic [NC-1:0]   core_req_pc;
  logic [NC-1:0]   core_set_pc;
  logic [PW-1:0]   new_pc;
  logic            tbl_wen;
  logic [QW-1:0]   tbl_waddr;
  logic [PW-1:0]   tbl_wdata;
  logic [4:0]      count;
  logic            overflow;
  logic            idle;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [QW-1:0] mq[$];
  logic [PW-1:0] mtbl [16];
  logic [NC-1:0] m_set;
  logic [PW-1:0] m_pc;
  int            m_rr;
  bit            m_ovf;

  task_dispatcher #(.NUM_CORES(NC), .DEPTH(DEPTH), .QID_W(QW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst),
    .core_q_wen(core_q_wen), .core_q_num(core_q_num),
    .host_q_wen(host_q_wen), .host_q_num(host_q_num),
    .core_req_pc(core_req_pc), .core_set_pc(core_set_pc), .new_pc(new_pc),
    .tbl_wen(tbl_wen), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .count(count), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_push(input logic [QW-1:0] num);
    if (mq.size() < DEPTH) mq.push_back(num);
    else m_ovf = 1'b1;
  endtask

  // Apply one clock edge to the model using the inputs held at that edge.
  task automatic model_edge();
    logic [NC-1:0] elig;
    logic [NC-1:0] nset;
    int win;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 16; i++) mtbl[i] = 16'h0000;
      m_set = '0; m_pc = '0; m_rr = 0; m_ovf = 1'b0;
    end else begin
      elig = core_req_pc & ~m_set;
      nset = '0;
      if (mq.size() != 0 && elig != '0) begin
        win = -1;
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (m_rr + k) % NC;
          if (win < 0 && elig[c]) win = c;
        end
        nset[win] = 1'b1;
        m_pc = mtbl[mq.pop_front()];
        m_rr = (win + 1) % NC;
      end
      m_set = nset;
      if (host_q_wen) model_push(host_q_num);
      for (int i = 0; i < NC; i++)
        if (core_q_wen[i]) model_push(core_q_num[i*QW +: QW]);
      if (tbl_wen) mtbl[tbl_waddr] = tbl_wdata;
    end
  endtask

  // One cycle: check idle mid-cycle, clock, update model, compare outputs.
  task automatic tick();
    @(negedge clk);
    check_val("idle", {31'b0, idle}, {31'b0, (mq.size() == 0) && (&core_req_pc)});
    @(posedge clk);
    model_edge();
    #1;
    check_val("core_set_pc", {28'b0, core_set_pc}, {28'b0, m_set});
    check_val("new_pc", {16'b0, new_pc}, {16'b0, m_pc});
    check_val("count", {27'b0, count}, 32'(mq.size()));
    check_val("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic clear_strobes();
    core_q_wen = '0; host_q_wen = 1'b0; tbl_wen = 1'b0; rst = 1'b0;
  endtask

  task automatic push_host(input int n, input logic [QW-1:0] num);
    for (int i = 0; i < n; i++) begin
      host_q_wen = 1'b1; host_q_num = num;
      tick();
    end
    host_q_wen = 1'b0;
  endtask

  task automatic do_reset();
    clear_strobes();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_strobes();
    core_q_num = '0; host_q_num = '0; core_req_pc = '0;
    tbl_waddr = '0; tbl_wdata = '0;
    for (int i = 0; i < 16; i++) mtbl[i] = 16'h0000;
    m_set = '0; m_pc = '0; m_rr = 0; m_ovf = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // basic dispatch: table[3]=0x0040, host pushes 3
    core_req_pc = 4'hF;
    tbl_wen = 1'b1; tbl_waddr = 4'd3; tbl_wdata = 16'h0040;
    tick();
    tbl_wen = 1'b0;
    host_q_wen = 1'b1; host_q_num = 4'd3;
    tick();
    host_q_wen = 1'b0;
    tick();
    check_val("basic_grant", {28'b0, core_set_pc}, 32'h1);
    check_val("basic_pc", {16'b0, new_pc}, 32'h0040);
    tick();
    tick();

    // round robin: four tasks, cores drop their request after the grant
    core_req_pc = '0;
    for (int i = 0; i < 4; i++) begin
      tbl_wen = 1'b1; tbl_waddr = 4'(i + 8); tbl_wdata = 16'(16'h1000 + i);
      host_q_wen = 1'b1; host_q_num = 4'(i + 8);
      tick();
    end
    clear_strobes();
    core_req_pc = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      core_req_pc = core_req_pc & ~core_set_pc;
    end

    // push and pop on full: count stays DEPTH, no overflow
    do_reset();
    core_req_pc = '0;
    push_host(DEPTH, 4'd5);
    core_req_pc = 4'b0010;
    core_q_wen = 4'b1000; core_q_num = 16'h7000;
    tick();
    clear_strobes();
    core_req_pc = '0;
    tick();

    // simultaneous pushes with two free slots: core 2 dropped
    do_reset();
    push_host(DEPTH - 2, 4'd1);
    host_q_wen = 1'b1; host_q_num = 4'd2;
    core_q_wen = 4'b0101; core_q_num = 16'h0403;
    tick();
    clear_strobes();
    tick();
    tick();

    // reset mid-run with tasks queued and a grant pending
    do_reset();
    tbl_wen = 1'b1; tbl_waddr = 4'd6; tbl_wdata = 16'hBEEF;
    push_host(5, 4'd6);
    tbl_wen = 1'b0;
    core_req_pc = 4'b0100;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    host_q_wen = 1'b1; host_q_num = 4'd6;
    tick();
    clear_strobes();
    tick();
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst         = ($urandom_range(0, 249) == 0);
      host_q_wen  = ($urandom_range(0, 3) == 0);
      host_q_num  = 4'($urandom);
      for (int i = 0; i < NC; i++) core_q_wen[i] = ($urandom_range(0, 6) == 0);
      core_q_num  = 16'($urandom);
      core_req_pc = 4'($urandom);
      tbl_wen     = ($urandom_range(0, 3) == 0);
      tbl_waddr   = 4'($urandom);
      tbl_wdata   = 16'($urandom);
      tick();
    end
    clear_strobes();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
